sig_freq_meter: RTL and testbench
=================================

Name: sig_freq_meter

Overview:
- Reads back a free-running external or loop-back signal, such as the IOBUF ring-oscillator node or an LED/clock test pin.
- Measures its frequency by counting rising edges over a fixed gate window timed by the system clock.
- This is the receive/measure end of the counter-driven toggle output. Board bring-up uses it to confirm an output pin or oscillator is actually toggling, and at what rate.
- The result is latched once per window, with a one-cycle valid pulse and an overflow flag.

Parameters:
- GATE_CYCLES, 50_000_000: gate window length in clk cycles, ≥ 4. This is 1 s at 50 MHz, giving a count in Hz.
- CNT_W, 32: width of the edge counter and of the result.
- SYNC_STAGES, 2: metastability synchronizer depth for sig_in, ≥ 2.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset. Assertion is asynchronous; release is synchronous to clk.
- sig_in  in  1  signal under measurement, asynchronous to clk.
- enable  in  1  run measurements while high.
- meas_count  out  CNT_W  rising edges counted in the last completed window.
- meas_valid  out  1  one-cycle pulse when meas_count/meas_ovf update.
- meas_ovf  out  1  the last completed window saturated the edge counter.
- busy  out  1  high while a window is in progress (GATE state).

Behaviour:
- Reset values:
  - meas_count=0, meas_valid=0, meas_ovf=0, busy=0.
  - FSM=IDLE, all counters 0, synchronizer flops 0.
- Input path:
  - SYNC_STAGES flops feed an edge register.
  - rise = synced & ~prev.
  - Latency from a sig_in rising edge to its counter increment is SYNC_STAGES+1 clk cycles.
- FSM states and transitions:
  - IDLE: counters held at 0; busy=0.
    - enable=1 → FLUSH.
  - FLUSH: edge detection suppressed for SYNC_STAGES+1 cycles so stale synchronizer contents are discarded.
    - Then → GATE with gate_cnt=0, edge_cnt=0.
  - GATE: busy=1. gate_cnt increments each cycle; edge_cnt increments on rise.
    - At gate_cnt==GATE_CYCLES-1:
      - Latch meas_count = edge_cnt + rise, saturated.
      - Latch meas_ovf = the window's saturation flag.
      - Pulse meas_valid on the next cycle.
    - Same-cycle restart: if enable=1, reset gate_cnt and edge_cnt and stay in GATE. Windows are gapless, so no edge is lost between windows.
    - If enable=0 at the terminal cycle, the result is still latched and reported, then → IDLE.
- Abort:
  - enable=0 before the terminal cycle aborts the window and goes → IDLE next cycle.
  - No meas_valid pulse; meas_count/meas_ovf keep the previous result.
- Saturation:
  - edge_cnt stops at 2^CNT_W-1.
  - A per-window sticky ovf is set when a rise arrives with edge_cnt already at max.
  - The sticky ovf is cleared at window restart.
- Outputs are registered. meas_count/meas_ovf are stable from their update until the next valid pulse.
- The terminal-cycle rise is counted in the closing window, not the next one.
- Reset mid-window: immediate return to reset values. Any partial window is discarded.
- sig_in toggling faster than clk/2 undercounts. This is a documented limit, not detected.

Decomposition:
- Package sig_freq_meter_pkg:
  - FSM state enum (IDLE, FLUSH, GATE).
  - Function for the gate counter width: clog2(GATE_CYCLES).
- Sub-module sync_rise_det: SYNC_STAGES synchronizer plus rising-edge pulse, with a suppress input used during FLUSH.
  - Reusable for button and other asynchronous inputs.

Test Plan:
(All tests use GATE_CYCLES=100 unless stated.)
- Square-wave count: sig_in period 10 clk, enable=1 → every 100 cycles meas_valid pulses with meas_count=10, meas_ovf=0. Consecutive windows are gapless.
- Constant input: sig_in held 0, then held 1 → meas_count=0 in every window.
- Saturation: CNT_W=3, sig_in period 2 clk (50 rises per window) → meas_count=7, meas_ovf=1. Next window at period 20 → meas_count=5, meas_ovf=0.
- Abort: drop enable at gate cycle 50 → no meas_valid, meas_count holds the prior value. Re-enable → first valid appears SYNC_STAGES+1+100 cycles later.
- Window boundary: single rise timed so its increment lands on gate cycle 99 → counted in that window (count 1); next window count 0.
- Async reset: assert rst_n mid-GATE and away from any clk edge → all outputs 0 immediately. After release with enable=1, normal operation resumes via FLUSH.

Source files
------------

// File: rtl/sig_freq_meter_pkg.sv
// sig_freq_meter_pkg
//   Shared types and helpers for the signal frequency meter.
//   - state_e      : measurement FSM states
//   - cnt_width()  : bit width needed for a counter that runs 0..n-1
package sig_freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_GATE  = 2'd2
  } state_e;

  // clog2(n) with a floor of one bit, so tiny counts still get a real flop.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det
//   Multi-flop synchronizer for an asynchronous input followed by a
//   rising-edge detector. Usable for buttons, test pins and similar inputs.
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   async_in  in   input from another (or no) clock domain
//   suppress  in   forces rise low (used while stale sync contents drain)
//   rise      out  one-cycle pulse per synchronized 0->1 transition
module sync_rise_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic suppress,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // The edge register keeps tracking during suppression, so once suppress
  // drops only a genuinely new transition can produce a pulse.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q & ~suppress;

endmodule

// File: rtl/sig_freq_meter.sv
// sig_freq_meter
//   Counts rising edges of an asynchronous signal over a gate window of
//   GATE_CYCLES clk cycles. Windows run back to back while enable is high;
//   each completed window latches its count and a saturation flag and emits
//   a one-cycle valid pulse.
// Ports:
//   clk         in   system clock (only clock)
//   rst_n       in   asynchronous active-low reset
//   sig_in      in   signal under measurement (asynchronous)
//   enable      in   run measurements while high
//   meas_count  out  rising edges seen in the last completed window
//   meas_valid  out  one-cycle pulse when meas_count/meas_ovf update
//   meas_ovf    out  last completed window saturated the edge counter
//   busy        out  a gate window is in progress
module sig_freq_meter
  import sig_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             meas_ovf,
  output logic             busy
);

  localparam int             GW         = cnt_width(GATE_CYCLES);
  localparam int             FW         = cnt_width(SYNC_STAGES + 1);
  localparam logic [GW-1:0]  GATE_LAST  = GW'(GATE_CYCLES - 1);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] meas_count_q, meas_count_d;
  logic             meas_ovf_q, meas_ovf_d;
  logic             meas_valid_q, meas_valid_d;

  logic             rise;
  logic             edge_at_max;
  logic [CNT_W-1:0] edge_inc;
  logic             ovf_inc;

  sync_rise_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sig_in),
    .suppress (state_q == ST_FLUSH),
    .rise     (rise)
  );

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ovf_d        = ovf_q;
    meas_count_d = meas_count_q;
    meas_ovf_d   = meas_ovf_q;
    meas_valid_d = 1'b0;

    // Edge count including this cycle's rise, saturating at CNT_MAX; the
    // sticky flag records any rise that found the counter already full.
    edge_at_max = (edge_cnt_q == CNT_MAX);
    edge_inc    = (rise && !edge_at_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    ovf_inc     = ovf_q | (rise & edge_at_max);

    unique case (state_q)
      ST_IDLE: begin
        flush_cnt_d = '0;
        gate_cnt_d  = '0;
        edge_cnt_d  = '0;
        ovf_d       = 1'b0;
        if (enable) state_d = ST_FLUSH;
      end

      ST_FLUSH: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = ST_GATE;
          flush_cnt_d = '0;
          gate_cnt_d  = '0;
          edge_cnt_d  = '0;
          ovf_d       = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end

      ST_GATE: begin
        if (gate_cnt_q == GATE_LAST) begin
          // Terminal cycle: its own rise belongs to the closing window.
          meas_count_d = edge_inc;
          meas_ovf_d   = ovf_inc;
          meas_valid_d = 1'b1;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          ovf_d        = 1'b0;
          if (!enable) state_d = ST_IDLE;
        end else if (!enable) begin
          // Abort: partial window is dropped, previous result stays.
          state_d = ST_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = edge_inc;
          ovf_d      = ovf_inc;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      meas_count_q <= '0;
      meas_ovf_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_q        <= ovf_d;
      meas_count_q <= meas_count_d;
      meas_ovf_q   <= meas_ovf_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign meas_count = meas_count_q;
  assign meas_ovf   = meas_ovf_q;
  assign meas_valid = meas_valid_q;
  assign busy       = (state_q == ST_GATE);

endmodule

// File: tb/tb_sig_freq_meter.sv
// tb_sig_freq_meter
//   Two meters (32-bit and 3-bit counters) share one stimulus stream and are
//   compared every cycle against a window-level reference model that keeps
//   an unbounded rise total per window and derives count/overflow from it.
module tb_sig_freq_meter;

  localparam int GATE   = 100;
  localparam int SYNC   = 2;
  localparam int W_BIG  = 32;
  localparam int W_SML  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_in;
  logic enable;

  logic [W_BIG-1:0] meas_count;
  logic             meas_valid, meas_ovf, busy;
  logic [W_SML-1:0] s_meas_count;
  logic             s_meas_valid, s_meas_ovf, s_busy;

  always #5 clk = ~clk;

  sig_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(W_BIG), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .meas_count (meas_count),
    .meas_valid (meas_valid),
    .meas_ovf   (meas_ovf),
    .busy       (busy)
  );

  sig_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(W_SML), .SYNC_STAGES(SYNC)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .enable     (enable),
    .meas_count (s_meas_count),
    .meas_valid (s_meas_valid),
    .meas_ovf   (s_meas_ovf),
    .busy       (s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 idle, 1 flushing, 2 measuring. A rise reaches the counter
  // SYNC+1 edges after the edge that first samples the new level.
  int     m_mode  = 0;
  int     m_left  = 0;
  int     m_pos   = 0;
  longint m_total = 0;
  longint m_res   = 0;
  bit     m_valid = 0;
  bit     past [1:SYNC+1];

  function automatic longint exp_cnt(input longint total, input int w);
    longint mx = (64'd1 << w) - 1;
    return (total > mx) ? mx : total;
  endfunction

  function automatic longint exp_ovf(input longint total, input int w);
    longint mx = (64'd1 << w) - 1;
    return (total > mx) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= SYNC + 1; k++) past[k] = 1'b0;
      m_mode = 0; m_left = 0; m_pos = 0; m_total = 0; m_res = 0; m_valid = 0;
    end else begin
      bit r;
      r = past[SYNC] & ~past[SYNC+1];
      for (int k = SYNC + 1; k > 1; k--) past[k] = past[k-1];
      past[1] = sig_in;
      m_valid = 0;
      case (m_mode)
        0: if (enable) begin m_mode = 1; m_left = SYNC + 1; end
        1: begin
          if (!enable) m_mode = 0;
          else begin
            m_left--;
            if (m_left == 0) begin m_mode = 2; m_pos = 0; m_total = 0; end
          end
        end
        default: begin
          if (r) m_total++;
          if (m_pos == GATE - 1) begin
            m_res = m_total; m_valid = 1;
            m_pos = 0; m_total = 0;
            if (!enable) m_mode = 0;
          end else if (!enable) begin
            m_mode = 0;
          end else begin
            m_pos++;
          end
        end
      endcase
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",    meas_valid,   m_valid);
      check("count",    meas_count,   exp_cnt(m_res, W_BIG));
      check("ovf",      meas_ovf,     exp_ovf(m_res, W_BIG));
      check("busy",     busy,         (m_mode == 2) ? 1 : 0);
      check("s_valid",  s_meas_valid, m_valid);
      check("s_count",  s_meas_count, exp_cnt(m_res, W_SML));
      check("s_ovf",    s_meas_ovf,   exp_ovf(m_res, W_SML));
      check("s_busy",   s_busy,       (m_mode == 2) ? 1 : 0);
    end
  end

  // ---------------- stimulus generator ----------------
  // 0: main drives sig_in directly, 1: square wave, 2: random per cycle.
  int gen_mode   = 0;
  int gen_period = 10;
  int gen_phase  = 0;
  always @(negedge clk) begin
    if (gen_mode == 1) begin
      gen_phase = (gen_phase + 1) % gen_period;
      sig_in    = (gen_phase < gen_period / 2);
    end else if (gen_mode == 2) begin
      sig_in = 1'($urandom_range(0, 1));
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!meas_valid && n < 400);
    if (!meas_valid) check("valid_timeout", 0, 1);
    $display("window: count=%0d ovf=%0d s_count=%0d s_ovf=%0d after %0d cycles",
             meas_count, meas_ovf, s_meas_count, s_meas_ovf, n);
  endtask

  initial begin
    int n;
    int seen;
    rst_n  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", meas_count, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_ovf",   meas_ovf,   0);
    check("rst_busy",  busy,       0);
    chk_en = 1;
    rst_n  = 1'b1;
    repeat (3) @(negedge clk);

    // Square wave, period 10: gapless windows of exactly 10 rises.
    gen_period = 10; gen_mode = 1; enable = 1'b1;
    wait_valid(n);
    wait_valid(n);
    check("sq_gap",     n, GATE);
    check("sq_count",   meas_count, 10);
    check("sq_ovf",     meas_ovf, 0);
    check("sq_s_count", s_meas_count, 7);
    check("sq_s_ovf",   s_meas_ovf, 1);

    // Constant 0, then constant 1.
    gen_mode = 0; sig_in = 1'b0;
    wait_valid(n); wait_valid(n);
    check("const0_count", meas_count, 0);
    sig_in = 1'b1;
    wait_valid(n); wait_valid(n);
    check("const1_count", meas_count, 0);

    // Saturation of the 3-bit meter at 50 rises, then recovery at 5 rises.
    gen_period = 2; gen_mode = 1;
    wait_valid(n); wait_valid(n);
    check("sat_count",   meas_count, 50);
    check("sat_s_count", s_meas_count, 7);
    check("sat_s_ovf",   s_meas_ovf, 1);
    gen_period = 20;
    wait_valid(n); wait_valid(n);
    check("p20_s_count", s_meas_count, 5);
    check("p20_s_ovf",   s_meas_ovf, 0);

    // Abort at gate cycle 50: no pulse, previous result kept.
    wait_valid(n);
    repeat (50) @(negedge clk);
    enable = 1'b0;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (meas_valid) seen++;
    end
    check("abort_pulses", seen, 0);
    check("abort_hold",   meas_count, 5);
    check("abort_busy",   busy, 0);
    enable = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!meas_valid && n < 400);
    check("reenable_latency", n, SYNC + 1 + GATE);
    @(negedge clk);

    // Window boundary: one rise whose increment lands on the terminal cycle.
    gen_mode = 0; sig_in = 1'b0;
    wait_valid(n);
    wait_valid(n);
    repeat (97) @(negedge clk);
    sig_in = 1'b1;
    wait_valid(n);
    check("boundary_count", meas_count, 1);
    wait_valid(n);
    check("boundary_next",  meas_count, 0);

    // Random activity, model-checked every cycle.
    gen_mode = 2;
    repeat (4) wait_valid(n);

    // Asynchronous reset in the middle of a window.
    gen_period = 10; gen_mode = 1;
    repeat (30) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_count",   meas_count, 0);
    check("arst_valid",   meas_valid, 0);
    check("arst_ovf",     meas_ovf, 0);
    check("arst_busy",    busy, 0);
    check("arst_s_count", s_meas_count, 0);
    check("arst_s_ovf",   s_meas_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    check("post_rst_count", meas_count, 10);
    wait_valid(n);
    check("post_rst_gap",   n, GATE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
